dmem_store_buffer: RTL and testbench

//  Posted-write store buffer between the single-cycle core's data port
//  (memwrite/aluout/writedata/readdata) and the data RAM.

---
 rtl/dmem_store_buffer.sv | 167 ++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// dmem_store_buffer
//
// Posted-write store buffer between a single-cycle core's data port and the
// data RAM. Core stores go into a small circular FIFO and drain to the RAM
// write port under a valid/ready handshake. Loads read the RAM directly,
// but a pending buffered store to the same word overrides the RAM data.
// The youngest such store wins. The core is stalled only when it issues a
// store into a full buffer that is not draining in the same cycle.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          asynchronous active-high reset; drops all queued stores
//   memwrite_i       core word-store request this cycle
//   addr_i           core byte address (ALU result)
//   writedata_i      core store data
//   readdata_o       load data to the core (combinational)
//   stall_o          core must hold PC/state this cycle and replay the store
//   mem_rd_addr_o    RAM read address (passes addr_i through)
//   mem_rd_data_i    RAM combinational read data
//   mem_wr_valid_o   head entry presented to the RAM
//   mem_wr_ready_i   RAM accepts the head entry this cycle
//   mem_wr_addr_o    head word address, byte offset forced to zero
//   mem_wr_data_o    head store data
//   count_o          number of occupied entries
//   empty_o          buffer holds no stores (used by fence/flush logic)
// -----------------------------------------------------------------------------
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       memwrite_i,
  input  logic [AW-1:0]              addr_i,
  input  logic [31:0]                writedata_i,
  output logic [31:0]                readdata_o,
  output logic                       stall_o,
  output logic [AW-1:0]              mem_rd_addr_o,
  input  logic [31:0]                mem_rd_data_i,
  output logic                       mem_wr_valid_o,
  input  logic                       mem_wr_ready_i,
  output logic [AW-1:0]              mem_wr_addr_o,
  output logic [31:0]                mem_wr_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage. Kept in flops, not RAM: every entry is compared against
  // the load address in parallel.
  logic [AW-3:0]    ent_addr_q [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_valid_q;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [DEPTH-1:0] hit;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PW-1:0]    fwd_idx;

  // The byte offset plays no part in matching or draining.
  logic             unused_byte_offset;
  assign unused_byte_offset = ^addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Occupancy and handshake
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Valid comes from registered state only, so the RAM never sees a
  // combinational path from the core's store request.
  assign mem_wr_valid_o = !empty;
  assign pop            = mem_wr_valid_o & mem_wr_ready_i;

  // A full buffer can still accept a store when the head leaves in the same
  // cycle. The freed slot is the one wr_ptr points at.
  assign push    = memwrite_i & (!full | pop);
  assign stall_o = memwrite_i & full & !mem_wr_ready_i;

  assign count_d  = count_q + CW'(push) - CW'(pop);
  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-entry storage and load-address compare
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Push takes priority over pop. In a full push+pop cycle both
      // pointers address the same slot, and that slot must stay valid
      // with the new store.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          ent_valid_q[gi] <= 1'b0;
          ent_addr_q[gi]  <= '0;
          ent_data_q[gi]  <= '0;
        end else if (push && (wr_ptr_q == PW'(gi))) begin
          ent_valid_q[gi] <= 1'b1;
          ent_addr_q[gi]  <= addr_i[AW-1:2];
          ent_data_q[gi]  <= writedata_i;
        end else if (pop && (rd_ptr_q == PW'(gi))) begin
          ent_valid_q[gi] <= 1'b0;
        end
      end

      assign hit[gi] = ent_valid_q[gi] && (ent_addr_q[gi] == addr_i[AW-1:2]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Forwarding select
  // ---------------------------------------------------------------------------
  // Valid entries are contiguous starting at rd_ptr. The loop walks them
  // from oldest to youngest. A later hit overrides an earlier one, so the
  // youngest matching store supplies the data. An entry popping this
  // cycle is still valid here, so it still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (hit[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[fwd_idx];
      end
    end
  end

  assign readdata_o    = (!memwrite_i && fwd_hit) ? fwd_data : mem_rd_data_i;
  assign mem_rd_addr_o = addr_i;

  // ---------------------------------------------------------------------------
  // RAM write port: head of the FIFO
  // ---------------------------------------------------------------------------
  assign mem_wr_addr_o = {ent_addr_q[rd_ptr_q], 2'b00};
  assign mem_wr_data_o = ent_data_q[rd_ptr_q];
  assign count_o       = count_q;
  assign empty_o       = empty;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          memwrite;
  logic [AW-1:0] addr;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          stall;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [CW-1:0] count;
  logic          empty;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t sb_q[$];
  int  m_count;
  int  checks;
  int  failures;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .memwrite_i     (memwrite),
    .addr_i         (addr),
    .writedata_i    (writedata),
    .readdata_o     (readdata),
    .stall_o        (stall),
    .mem_rd_addr_o  (mem_rd_addr),
    .mem_rd_data_i  (mem_rd_data),
    .mem_wr_valid_o (mem_wr_valid),
    .mem_wr_ready_i (mem_wr_ready),
    .mem_wr_addr_o  (mem_wr_addr),
    .mem_wr_data_o  (mem_wr_data),
    .count_o        (count),
    .empty_o        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Combinational RAM read model
  assign mem_rd_data = ram_val(mem_rd_addr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // The youngest pending store to the same word wins, otherwise RAM.
  function automatic logic [31:0] exp_load(input logic [31:0] a);
    logic [31:0] r;
    r = ram_val(a);
    foreach (sb_q[i]) if (sb_q[i].a[31:2] == a[31:2]) r = sb_q[i].d;
    return r;
  endfunction

  // Called at a negedge with inputs already driven. It checks all outputs
  // before the rising edge and updates the model. It returns at the next
  // negedge.
  task automatic tick();
    logic exp_stall, do_pop, do_push;
    st_t  e;
    #1;
    exp_stall = memwrite && (m_count == DEPTH) && !mem_wr_ready;
    check_val("count",    32'(count),        32'(m_count));
    check_val("empty",    32'(empty),        32'(m_count == 0));
    check_val("wr_valid", 32'(mem_wr_valid), 32'(m_count != 0));
    check_val("stall",    32'(stall),        32'(exp_stall));
    if (!memwrite) check_val("readdata", readdata, exp_load(addr));
    do_pop  = (m_count != 0) && mem_wr_ready;
    do_push = memwrite && !exp_stall;
    if (do_pop) begin
      e = sb_q.pop_front();
      check_val("drain_addr", mem_wr_addr, {e.a[31:2], 2'b00});
      check_val("drain_data", mem_wr_data, e.d);
      $display("drain addr=%h data=%h", mem_wr_addr, mem_wr_data);
    end
    if (do_push) begin
      sb_q.push_back('{a: addr, d: writedata});
      $display("store addr=%h data=%h", addr, writedata);
    end
    if (!memwrite) $display("load  addr=%h data=%h", addr, readdata);
    m_count = m_count + int'(do_push) - int'(do_pop);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    tick();
  endtask

  task automatic drain_all();
    int guard;
    memwrite     = 1'b0;
    mem_wr_ready = 1'b1;
    guard        = 0;
    while (m_count != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check_val("drain_done", 32'(m_count), 32'd0);
    #1;
    check_val("empty_after_drain", 32'(empty), 32'd1);
  endtask

  initial begin
    int n, guard;
    logic ok;
    checks = 0; failures = 0; m_count = 0;
    reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0; mem_wr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: async reset drops queued stores
    store(32'h100, 32'h1111_0001);
    store(32'h104, 32'h1111_0002);
    store(32'h108, 32'h1111_0003);
    check_val("t1_count3", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check_val("t1_rst_count", 32'(count),        32'd0);
    check_val("t1_rst_empty", 32'(empty),        32'd1);
    check_val("t1_rst_valid", 32'(mem_wr_valid), 32'd0);
    sb_q.delete();
    m_count = 0;
    // Hold the store request across an edge while reset is asserted.
    @(negedge clk);
    @(negedge clk);
    check_val("t1_rst_memwrite", 32'(count), 32'd0);
    reset = 1'b0; memwrite = 1'b0; mem_wr_ready = 1'b1; addr = 32'h100;
    tick();
    tick();

    // 2: single store, latency 1
    mem_wr_ready = 1'b1;
    store(32'h10, 32'hAAAA_0001);
    memwrite = 1'b0; addr = 32'h0;
    #1;
    check_val("t2_valid", 32'(mem_wr_valid), 32'd1);
    check_val("t2_addr",  mem_wr_addr, 32'h10);
    tick();
    check_val("t2_empty", 32'(empty), 32'd1);

    // 3: forwarding picks the youngest matching store
    mem_wr_ready = 1'b0;
    store(32'h20, 32'h1);
    store(32'h24, 32'h2);
    store(32'h20, 32'h3);
    memwrite = 1'b0; addr = 32'h20;
    #1 check_val("t3_ld20", readdata, 32'h3);
    tick();
    addr = 32'h22;
    #1 check_val("t3_ld22", readdata, 32'h3);
    tick();
    addr = 32'h28;
    #1 check_val("t3_ld28", readdata, ram_val(32'h28));
    tick();
    drain_all();

    // 4: full buffer stall, then simultaneous push and pop
    mem_wr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) store(32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    memwrite = 1'b1; addr = 32'h310; writedata = 32'hB000_0004;
    #1;
    check_val("t4_stall",   32'(stall), 32'd1);
    check_val("t4_count",   32'(count), 32'd4);
    mem_wr_ready = 1'b1;
    #1 check_val("t4_nostall", 32'(stall), 32'd0);
    tick();
    check_val("t4_count_after", 32'(count), 32'd4);
    drain_all();

    // 5: random ready, 8 stores; pointers wrap twice
    n = 0; guard = 0;
    while (n < 8 && guard < 200) begin
      memwrite     = 1'b1;
      addr         = 32'h200 + 32'(4 * n);
      writedata    = $urandom;
      mem_wr_ready = 1'($urandom_range(0, 1));
      ok = !((m_count == DEPTH) && !mem_wr_ready);
      tick();
      if (ok) n++;
      guard++;
    end
    check_val("t5_all_stored", 32'(n), 32'd8);
    drain_all();

    // 6: head entry forwards in the cycle it pops, RAM afterwards
    mem_wr_ready = 1'b0;
    store(32'h40, 32'hC0DE_0006);
    store(32'h44, 32'hC0DE_0007);
    store(32'h48, 32'hC0DE_0008);
    memwrite = 1'b0; addr = 32'h40; mem_wr_ready = 1'b1;
    #1 check_val("t6_fwd_pop", readdata, 32'hC0DE_0006);
    tick();
    check_val("t6_after_pop", readdata, ram_val(32'h40));
    drain_all();

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
